// File: rtl/hazard_ctrl_id_ex_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_id_ex_if
//   Bundles the signals exchanged between the ID/EX hazard controller and the
//   surrounding pipeline.
//   master : pipeline side (drives decode/EX/MEM status, reads controls)
//   slave  : hazard controller side
//   Signals:
//     id_rs, id_rt      source register fields of the instruction in ID
//     id_uses_rt        ID instruction reads rt
//     ex_mem_to_reg     EX instruction is a load
//     ex_reg_write      EX instruction writes a register
//     ex_dst            EX destination register
//     mem_branch_taken  branch resolved taken in MEM this cycle
//     clr_cnt           synchronous clear of both event counters
//     pc_write          PC may advance
//     ifid_write        IF/ID latch may load
//     ifid_flush        IF/ID loads a NOP
//     idex_bubble       ID/EX control fields load zero
//     state             FSM state (0 RUN, 1 STALL, 2 FLUSH)
//     stall_cnt         saturating count of stalled cycles
//     flush_cnt         saturating count of flushing cycles
// ---------------------------------------------------------------------------
interface hazard_ctrl_id_ex_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_to_reg;
  logic             ex_reg_write;
  logic [4:0]       ex_dst;
  logic             mem_branch_taken;
  logic             clr_cnt;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_to_reg, ex_reg_write, ex_dst,
           mem_branch_taken, clr_cnt,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, state,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_to_reg, ex_reg_write, ex_dst,
           mem_branch_taken, clr_cnt,
    output pc_write, ifid_write, ifid_flush, idex_bubble, state,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_id_ex.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_id_ex
//   Hazard controller for the IF/ID and ID/EX pipeline latches.
//   - Load-use: when the load in EX targets a register read by the
//     instruction in ID, PC and IF/ID are frozen and a bubble is injected
//     into ID/EX for LOAD_STALL_CYCLES cycles.
//   - Taken branch in MEM: IF/ID and ID/EX are flushed for FLUSH_CYCLES
//     cycles; a branch always overrides an ongoing stall.
//   - Saturating counters track stalled and flushing cycles.
//   Control outputs are Mealy (combinational from state and inputs), so a
//   hazard acts in the very cycle it is seen.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous reset, active low; forces idle outputs while low
//     bus  hazard_ctrl_id_ex_if.slave (see interface file for signals)
// ---------------------------------------------------------------------------
module hazard_ctrl_id_ex #(
  parameter int LOAD_STALL_CYCLES = 1,  // 1..7
  parameter int FLUSH_CYCLES      = 1,  // 1..7
  parameter int CNT_W             = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_ctrl_id_ex_if.slave   bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // rem counts the cycles still to go after the current one; the entry
  // cycle is spent in RUN, hence the -2.
  localparam logic [2:0] STALL_RELOAD =
    (LOAD_STALL_CYCLES > 1) ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;
  localparam logic [2:0] FLUSH_RELOAD =
    (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic stall_req;   // stall outputs requested by the FSM
  logic flush_req;   // flush outputs requested by the FSM
  logic stall_act;   // requests gated by reset
  logic flush_act;

  // Load-use detection; register 0 is hard-wired and never a hazard.
  assign hazard = bus.ex_mem_to_reg & bus.ex_reg_write &
                  (bus.ex_dst != 5'd0) &
                  ((bus.ex_dst == bus.id_rs) |
                   (bus.id_uses_rt & (bus.ex_dst == bus.id_rt)));

  // Next-state and output request logic
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    stall_req = 1'b0;
    flush_req = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.mem_branch_taken) begin
          flush_req = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            rem_d   = FLUSH_RELOAD;
          end
        end else if (hazard) begin
          stall_req = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = ST_STALL;
            rem_d   = STALL_RELOAD;
          end
        end
      end

      ST_STALL: begin
        // A taken branch squashes the stalled instruction anyway, so the
        // stall is abandoned in favour of a fresh flush sequence.
        if (bus.mem_branch_taken) begin
          flush_req = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            rem_d   = FLUSH_RELOAD;
          end else begin
            state_d = ST_RUN;
            rem_d   = 3'd0;
          end
        end else begin
          stall_req = 1'b1;
          if (rem_q == 3'd0) begin
            state_d = ST_RUN;
          end else begin
            rem_d = rem_q - 3'd1;
          end
        end
      end

      ST_FLUSH: begin
        flush_req = 1'b1;
        if (bus.mem_branch_taken) begin
          if (FLUSH_CYCLES > 1) begin
            rem_d = FLUSH_RELOAD;
          end else begin
            state_d = ST_RUN;
            rem_d   = 3'd0;
          end
        end else if (rem_q == 3'd0) begin
          state_d = ST_RUN;
        end else begin
          rem_d = rem_q - 3'd1;
        end
      end

      default: begin
        state_d = ST_RUN;
        rem_d   = 3'd0;
      end
    endcase
  end

  // Outputs fall back to idle values while reset is held low.
  assign stall_act = stall_req & rst;
  assign flush_act = flush_req & rst;

  assign bus.pc_write    = ~stall_act;
  assign bus.ifid_write  = ~stall_act;
  assign bus.ifid_flush  = flush_act;
  assign bus.idex_bubble = stall_act | flush_act;
  assign bus.state       = state_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

  // Saturating event counters; clear beats increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_act && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (flush_act && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      rem_q       <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_id_ex.sv
module tb_hazard_ctrl_id_ex;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_dst = '0;
  logic       id_uses_rt = 1'b0, ex_mem_to_reg = 1'b0, ex_reg_write = 1'b0;
  logic       br = 1'b0, clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Three configurations: defaults, multi-cycle stall/flush, narrow counters.
  hazard_ctrl_id_ex_if #(.CNT_W(16)) bus_a ();
  hazard_ctrl_id_ex_if #(.CNT_W(16)) bus_b ();
  hazard_ctrl_id_ex_if #(.CNT_W(2))  bus_c ();

  hazard_ctrl_id_ex #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  hazard_ctrl_id_ex #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(16))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  hazard_ctrl_id_ex #(.LOAD_STALL_CYCLES(4), .FLUSH_CYCLES(3), .CNT_W(2))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  assign bus_a.id_rs = id_rs;  assign bus_b.id_rs = id_rs;  assign bus_c.id_rs = id_rs;
  assign bus_a.id_rt = id_rt;  assign bus_b.id_rt = id_rt;  assign bus_c.id_rt = id_rt;
  assign bus_a.id_uses_rt = id_uses_rt;
  assign bus_b.id_uses_rt = id_uses_rt;
  assign bus_c.id_uses_rt = id_uses_rt;
  assign bus_a.ex_mem_to_reg = ex_mem_to_reg;
  assign bus_b.ex_mem_to_reg = ex_mem_to_reg;
  assign bus_c.ex_mem_to_reg = ex_mem_to_reg;
  assign bus_a.ex_reg_write = ex_reg_write;
  assign bus_b.ex_reg_write = ex_reg_write;
  assign bus_c.ex_reg_write = ex_reg_write;
  assign bus_a.ex_dst = ex_dst;  assign bus_b.ex_dst = ex_dst;  assign bus_c.ex_dst = ex_dst;
  assign bus_a.mem_branch_taken = br;
  assign bus_b.mem_branch_taken = br;
  assign bus_c.mem_branch_taken = br;
  assign bus_a.clr_cnt = clr;  assign bus_b.clr_cnt = clr;  assign bus_c.clr_cnt = clr;

  logic        o_pcw[3], o_ifw[3], o_ifl[3], o_bub[3];
  logic [1:0]  o_st[3];
  logic [15:0] o_sc[3], o_fc[3];

  assign o_pcw[0] = bus_a.pc_write;    assign o_pcw[1] = bus_b.pc_write;    assign o_pcw[2] = bus_c.pc_write;
  assign o_ifw[0] = bus_a.ifid_write;  assign o_ifw[1] = bus_b.ifid_write;  assign o_ifw[2] = bus_c.ifid_write;
  assign o_ifl[0] = bus_a.ifid_flush;  assign o_ifl[1] = bus_b.ifid_flush;  assign o_ifl[2] = bus_c.ifid_flush;
  assign o_bub[0] = bus_a.idex_bubble; assign o_bub[1] = bus_b.idex_bubble; assign o_bub[2] = bus_c.idex_bubble;
  assign o_st[0]  = bus_a.state;       assign o_st[1]  = bus_b.state;       assign o_st[2]  = bus_c.state;
  assign o_sc[0]  = bus_a.stall_cnt;   assign o_sc[1]  = bus_b.stall_cnt;   assign o_sc[2]  = {14'd0, bus_c.stall_cnt};
  assign o_fc[0]  = bus_a.flush_cnt;   assign o_fc[1]  = bus_b.flush_cnt;   assign o_fc[2]  = {14'd0, bus_c.flush_cnt};

  // Reference model: mode (0 run, 1 stall, 2 flush) plus number of
  // special cycles still owed after the current one.
  int cfg_l[3]  = '{1, 3, 4};
  int cfg_f[3]  = '{1, 2, 3};
  int cfg_mx[3] = '{65535, 65535, 3};
  int md[3]  = '{0, 0, 0};
  int lf[3]  = '{0, 0, 0};
  int msc[3] = '{0, 0, 0};
  int mfc[3] = '{0, 0, 0};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: inputs already set by the caller just after a rising
  // edge; outputs checked at the falling edge, model advanced at the next
  // rising edge.
  task automatic step();
    bit hz;
    bit es[3];
    bit ef[3];
    hz = ex_mem_to_reg && ex_reg_write && (ex_dst != 0) &&
         ((ex_dst == id_rs) || (id_uses_rt && ex_dst == id_rt));
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        md[i] = 0; lf[i] = 0; msc[i] = 0; mfc[i] = 0;
      end
      es[i] = 0;
      ef[i] = 0;
      if (rst) begin
        if (md[i] == 2 || br)      ef[i] = 1;
        else if (md[i] == 1 || hz) es[i] = 1;
      end
      check_val($sformatf("pc_write[%0d]", i),    32'(o_pcw[i]), 32'(!es[i]));
      check_val($sformatf("ifid_write[%0d]", i),  32'(o_ifw[i]), 32'(!es[i]));
      check_val($sformatf("ifid_flush[%0d]", i),  32'(o_ifl[i]), 32'(ef[i]));
      check_val($sformatf("idex_bubble[%0d]", i), 32'(o_bub[i]), 32'(es[i] | ef[i]));
      check_val($sformatf("state[%0d]", i),       32'(o_st[i]),  32'(md[i]));
      check_val($sformatf("stall_cnt[%0d]", i),   32'(o_sc[i]),  32'(msc[i]));
      check_val($sformatf("flush_cnt[%0d]", i),   32'(o_fc[i]),  32'(mfc[i]));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        if (clr) begin
          msc[i] = 0; mfc[i] = 0;
        end else begin
          if (es[i] && msc[i] < cfg_mx[i]) msc[i]++;
          if (ef[i] && mfc[i] < cfg_mx[i]) mfc[i]++;
        end
        if (ef[i] && br) begin
          if (cfg_f[i] > 1) begin md[i] = 2; lf[i] = cfg_f[i] - 1; end
          else begin md[i] = 0; lf[i] = 0; end
        end else if (md[i] == 0) begin
          if (es[i] && cfg_l[i] > 1) begin md[i] = 1; lf[i] = cfg_l[i] - 1; end
        end else begin
          lf[i]--;
          if (lf[i] == 0) md[i] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic [4:0] dst, input logic b, input logic c);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_dst = dst; br = b; clr = c;
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset held low
    ex_mem_to_reg = 1'b1; ex_reg_write = 1'b1;
    set_in(5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0);
    step(); step();
    rst = 1'b1;

    // No hazard
    set_in(5'd6, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0);
    repeat (3) step();
    check_val("nohaz_cnt", 32'(o_sc[0]), 32'd0);

    // Load-use for one cycle, then quiet
    set_in(5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0); step();
    set_in(5'd6, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0); repeat (4) step();
    check_val("lu_cnt_a", 32'(o_sc[0]), 32'd1);
    check_val("lu_cnt_b", 32'(o_sc[1]), 32'd3);

    // Branch during the second stall cycle
    clr = 1'b1; step(); clr = 1'b0;
    set_in(5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0); step();
    set_in(5'd6, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0); step();
    br = 1'b0; repeat (3) step();
    check_val("brstall_sc_b", 32'(o_sc[1]), 32'd1);
    check_val("brstall_fc_b", 32'(o_fc[1]), 32'd2);

    // Zero-register and rt-use gating
    clr = 1'b1; step(); clr = 1'b0;
    set_in(5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0); repeat (2) step();
    set_in(5'd3, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0); repeat (2) step();
    check_val("gate_cnt", 32'(o_sc[0]), 32'd0);

    // Reset in the middle of a flush
    set_in(5'd3, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0); step();
    br = 1'b0; rst = 1'b0; step();
    check_val("rstflush_state_c", 32'(o_st[2]), 32'd0);
    rst = 1'b1; step();

    // Five consecutive stall cycles, narrow counter saturates
    clr = 1'b1; step(); clr = 1'b0;
    set_in(5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0); repeat (5) step();
    check_val("sat_cnt_c", 32'(o_sc[2]), 32'd3);
    check_val("sat_cnt_a", 32'(o_sc[0]), 32'd5);

    // Clear together with a stall
    clr = 1'b1; step(); clr = 1'b0;
    check_val("clr_stall_a", 32'(o_sc[0]), 32'd0);
    set_in(5'd6, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0); repeat (5) step();

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      ex_dst        = 5'($urandom_range(0, 3));
      id_uses_rt    = 1'($urandom_range(0, 1));
      ex_mem_to_reg = ($urandom_range(0, 3) != 0);
      ex_reg_write  = ($urandom_range(0, 3) != 0);
      br            = ($urandom_range(0, 7) == 0);
      clr           = ($urandom_range(0, 31) == 0);
      rst           = ($urandom_range(0, 63) != 0);
      step();
    end
    rst = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
